// File: rtl/prbs_word_checker.sv
// ---------------------------------------------------------------------------
// PrbsWordChecker (module prbs_word_checker)
//
// Receive-side partner of the LFSR stimulus source. The source emits WIDTH-bit
// words from the PRBS x^8+x^6+x^5+x^4+1. This block watches that stream, or a
// device's Q output, on the same clock. It synchronises to the stream without
// a seed, declares lock, and then counts words that differ from the predicted
// sequence.
//
// Optional feature macro: PRBS_CHK_BIT_ERR_EN
//   defined   : Err_Cnt adds the number of differing bits per bad word.
//   undefined : Err_Cnt adds one per bad word.
//
// Ports
//   Clk      in   1      clock, rising edge
//   Rst      in   1      synchronous active-high reset
//   Data_In  in   WIDTH  received word
//   Valid    in   1      Data_In qualifier; nothing advances while low
//   Clr_Cnt  in   1      synchronous clear of Err_Cnt
//   Locked   out  1      checker locked to the stream
//   Err      out  1      one-cycle pulse for a mismatching word while locked
//   Err_Cnt  out  CNT_W  saturating error count
// ---------------------------------------------------------------------------
module prbs_word_checker #(
   parameter int WIDTH    = 4,
   parameter int LFSR_W   = 8,
   parameter int GOOD_CNT = 4,
   parameter int BAD_CNT  = 3,
   parameter int CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] Data_In,
   input  logic             Valid,
   input  logic             Clr_Cnt,
   output logic             Locked,
   output logic             Err,
   output logic [CNT_W-1:0] Err_Cnt
);

   localparam int FILL_N = LFSR_W / WIDTH;
   localparam int FILL_W = (FILL_N > 1) ? $clog2(FILL_N) : 1;
   localparam int GOOD_W = (GOOD_CNT > 1) ? $clog2(GOOD_CNT) : 1;
   localparam int BAD_W  = (BAD_CNT > 1) ? $clog2(BAD_CNT) : 1;
   localparam int INC_W  = $clog2(WIDTH + 1);

   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_N - 1);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_CNT - 1);
   localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_CNT - 1);
   // After a failed verify the offending word is already in the register,
   // so the fill count starts at one word rather than zero.
   localparam logic [FILL_W-1:0] FILL_AFTER_MISS = (FILL_N > 1) ? FILL_W'(1) : FILL_W'(0);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   state_e             state_q;
   logic [LFSR_W-1:0]  lfsr_q;
   logic [FILL_W-1:0]  fillCnt_q;
   logic [GOOD_W-1:0]  goodCnt_q;
   logic [BAD_W-1:0]   badCnt_q;
   logic               locked_q;
   logic               err_q;
   logic [CNT_W-1:0]   errCnt_q;

   logic [LFSR_W-1:0]  lfsrPred_d;
   logic [LFSR_W-1:0]  lfsrShift_d;
   logic [WIDTH-1:0]   predWord;
   logic [WIDTH-1:0]   diffBits;
   logic               wordMismatch;
   logic [INC_W-1:0]   errInc;
   logic [CNT_W:0]     cntSum;
   logic [CNT_W-1:0]   errCnt_d;

   // Run WIDTH single-bit generator steps from the current state. The bits
   // shifted in form the next expected word, MSB first, so the predicted
   // word is simply the low WIDTH bits of the advanced state.
   always_comb begin
      logic [LFSR_W-1:0] stepVal;
      stepVal = lfsr_q;
      for (int i = 0; i < WIDTH; i++) begin
         stepVal = {stepVal[LFSR_W-2:0], stepVal[7] ^ stepVal[5] ^ stepVal[4] ^ stepVal[3]};
      end
      lfsrPred_d = stepVal;
   end

   assign predWord     = lfsrPred_d[WIDTH-1:0];
   assign lfsrShift_d  = {lfsr_q[LFSR_W-WIDTH-1:0], Data_In};
   assign diffBits     = Data_In ^ predWord;
   assign wordMismatch = |diffBits;

   // Amount one bad word adds to the error count.
`ifdef PRBS_CHK_BIT_ERR_EN
   always_comb begin
      errInc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         errInc = errInc + INC_W'(diffBits[i]);
      end
   end
`else
   assign errInc = INC_W'(1);
`endif

   // Saturating add: a carry out of the count pins it at all-ones.
   assign cntSum   = {1'b0, errCnt_q} + (CNT_W+1)'(errInc);
   assign errCnt_d = cntSum[CNT_W] ? {CNT_W{1'b1}} : cntSum[CNT_W-1:0];

   // Sync state machine. HUNT loads received words straight into the
   // register until it holds a full, non-zero state. VERIFY then predicts
   // GOOD_CNT words in a row before lock is declared. LOCKED free-runs the
   // generator so a corrupted word never pollutes the prediction, and only a
   // run of BAD_CNT bad words sends it back to hunting. A clear request
   // takes priority over a count update in the same cycle, but Err still
   // pulses.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= HUNT;
         lfsr_q    <= '0;
         fillCnt_q <= '0;
         goodCnt_q <= '0;
         badCnt_q  <= '0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         errCnt_q  <= '0;
      end else begin
         err_q <= 1'b0;
         if (Clr_Cnt) begin
            errCnt_q <= '0;
         end
         if (Valid) begin
            case (state_q)
               HUNT: begin
                  lfsr_q <= lfsrShift_d;
                  if (fillCnt_q == FILL_LAST) begin
                     if (lfsrShift_d != '0) begin
                        state_q   <= VERIFY;
                        goodCnt_q <= '0;
                     end
                  end else begin
                     fillCnt_q <= fillCnt_q + FILL_W'(1);
                  end
               end
               VERIFY: begin
                  if (!wordMismatch) begin
                     lfsr_q <= lfsrPred_d;
                     if (goodCnt_q == GOOD_LAST) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        badCnt_q <= '0;
                     end else begin
                        goodCnt_q <= goodCnt_q + GOOD_W'(1);
                     end
                  end else begin
                     state_q   <= HUNT;
                     lfsr_q    <= lfsrShift_d;
                     fillCnt_q <= FILL_AFTER_MISS;
                  end
               end
               LOCKED: begin
                  lfsr_q <= lfsrPred_d;
                  if (wordMismatch) begin
                     err_q <= 1'b1;
                     if (!Clr_Cnt) begin
                        errCnt_q <= errCnt_d;
                     end
                     if (badCnt_q == BAD_LAST) begin
                        state_q   <= HUNT;
                        locked_q  <= 1'b0;
                        fillCnt_q <= '0;
                        badCnt_q  <= '0;
                     end else begin
                        badCnt_q <= badCnt_q + BAD_W'(1);
                     end
                  end else begin
                     badCnt_q <= '0;
                  end
               end
               default: begin
                  state_q   <= HUNT;
                  fillCnt_q <= '0;
                  locked_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign Locked  = locked_q;
   assign Err     = err_q;
   assign Err_Cnt = errCnt_q;

endmodule

// File: tb/tb_prbs_word_checker.sv
// ---------------------------------------------------------------------------
// TbPrbsWordChecker (module tb_prbs_word_checker)
//
// Drives two checkers from one stimulus stream. One uses the default 16-bit
// count and the other a 4-bit count, so counter saturation is reachable.
// Each stimulus cycle runs a word-level reference model and queues the
// expected outputs. A monitor pops one entry per clock after the sampling
// edge and compares it with both instances.
// ---------------------------------------------------------------------------
module tb_prbs_word_checker;

   localparam int WIDTH   = 4;
   localparam int SMALL_W = 4;
   localparam int BIG_MAX = 65535;
   localparam int SML_MAX = 15;

   typedef struct {
      logic        locked;
      logic        err;
      logic [15:0] cntM;
      logic [3:0]  cntS;
      string       tag;
   } exp_t;

   logic              Clk = 1'b0;
   logic              rst;
   logic              valid;
   logic [WIDTH-1:0]  dataIn;
   logic              clrCnt;

   logic              lockedM, errM;
   logic [15:0]       errCntM;
   logic              lockedS, errS;
   logic [SMALL_W-1:0] errCntS;

   int   checkCount = 0;
   int   errCount   = 0;
   int   pushCount  = 0;
   int   popCount   = 0;
   exp_t expQ[$];

   // Reference model state: mode 0 hunting, 1 verifying, 2 locked.
   int          mMode;
   logic [7:0]  mS;
   int          mFill, mGood, mBad;
   logic        mLocked;
   int          mCntM, mCntS;

   // Stimulus source generator state.
   logic [7:0]  srcS;

   always #5 Clk = ~Clk;

   prbs_word_checker #(.WIDTH(WIDTH), .LFSR_W(8), .GOOD_CNT(4), .BAD_CNT(3), .CNT_W(16)) dutMain (
      .Clk(Clk), .Rst(rst), .Data_In(dataIn), .Valid(valid), .Clr_Cnt(clrCnt),
      .Locked(lockedM), .Err(errM), .Err_Cnt(errCntM)
   );

   prbs_word_checker #(.WIDTH(WIDTH), .LFSR_W(8), .GOOD_CNT(4), .BAD_CNT(3), .CNT_W(SMALL_W)) dutSmall (
      .Clk(Clk), .Rst(rst), .Data_In(dataIn), .Valid(valid), .Clr_Cnt(clrCnt),
      .Locked(lockedS), .Err(errS), .Err_Cnt(errCntS)
   );

   // One serial generator step of x^8+x^6+x^5+x^4+1.
   function automatic logic [7:0] prbsStep(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // Advance one whole word (WIDTH serial steps).
   function automatic logic [7:0] prbsWord(input logic [7:0] s);
      logic [7:0] t;
      t = s;
      for (int i = 0; i < WIDTH; i++) t = prbsStep(t);
      return t;
   endfunction

   function automatic int badAmount(input logic [3:0] diff);
`ifdef PRBS_CHK_BIT_ERR_EN
      return $countones(diff);
`else
      return (diff != 4'h0) ? 1 : 0;
`endif
   endfunction

   // Word-level behavioural model of the checker for one clock.
   task automatic modelStep(input logic r, input logic v, input logic [3:0] d,
                            input logic c, output exp_t e);
      logic [7:0] nextS;
      logic [3:0] diff;
      e.err = 1'b0;
      if (r) begin
         mMode = 0; mS = 8'h00; mFill = 0; mGood = 0; mBad = 0;
         mLocked = 1'b0; mCntM = 0; mCntS = 0;
      end else begin
         if (c) begin
            mCntM = 0;
            mCntS = 0;
         end
         if (v) begin
            nextS = prbsWord(mS);
            diff  = d ^ nextS[3:0];
            if (mMode == 0) begin
               mS = {mS[3:0], d};
               mFill++;
               if (mFill >= 2 && mS != 8'h00) begin
                  mMode = 1;
                  mGood = 0;
               end
            end else if (mMode == 1) begin
               if (diff == 4'h0) begin
                  mS = nextS;
                  mGood++;
                  if (mGood == 4) begin
                     mMode = 2; mLocked = 1'b1; mBad = 0;
                  end
               end else begin
                  mS = {mS[3:0], d};
                  mMode = 0;
                  mFill = 1;
               end
            end else begin
               mS = nextS;
               if (diff != 4'h0) begin
                  e.err = 1'b1;
                  if (!c) begin
                     mCntM = (mCntM + badAmount(diff) > BIG_MAX) ? BIG_MAX : mCntM + badAmount(diff);
                     mCntS = (mCntS + badAmount(diff) > SML_MAX) ? SML_MAX : mCntS + badAmount(diff);
                  end
                  mBad++;
                  if (mBad == 3) begin
                     mMode = 0; mLocked = 1'b0; mFill = 0; mBad = 0;
                  end
               end else begin
                  mBad = 0;
               end
            end
         end
      end
      e.locked = mLocked;
      e.cntM   = 16'(mCntM);
      e.cntS   = 4'(mCntS);
   endtask

   // Drive one cycle of inputs on the falling edge and queue the expectation.
   task automatic applyStimulus(input logic r, input logic v, input logic [3:0] d,
                                input logic c, input string tag);
      exp_t e;
      @(negedge Clk);
      rst = r; valid = v; dataIn = d; clrCnt = c;
      modelStep(r, v, d, c, e);
      e.tag = tag;
      expQ.push_back(e);
      pushCount++;
   endtask

   task automatic sendWord(input logic [3:0] mask, input logic c, input string tag);
      srcS = prbsWord(srcS);
      applyStimulus(1'b0, 1'b1, srcS[3:0] ^ mask, c, tag);
   endtask

   task automatic cleanRun(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b0, 4'($urandom), 1'b0, "gap");
         sendWord(4'h0, 1'b0, tag);
      end
   endtask

   task automatic checkField(input string name, input string tag,
                             input logic [31:0] act, input logic [31:0] expv);
      checkCount++;
      if (act !== expv) begin
         errCount++;
         $display("[TB] FAIL %s at %s: got %0h expected %0h (t=%0t)", name, tag, act, expv, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checkField("Locked", e.tag, 32'(lockedM), 32'(e.locked));
      checkField("Err", e.tag, 32'(errM), 32'(e.err));
      checkField("Err_Cnt", e.tag, 32'(errCntM), 32'(e.cntM));
      checkField("LockedSmall", e.tag, 32'(lockedS), 32'(e.locked));
      checkField("ErrSmall", e.tag, 32'(errS), 32'(e.err));
      checkField("Err_CntSmall", e.tag, 32'(errCntS), 32'(e.cntS));
   endtask

   // Monitor: outputs are registered, so each queued entry is due just after
   // the rising edge that sampled its inputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            popCount++;
            checkOutput(e);
         end
      end
   end

   initial begin
      rst = 1'b1; valid = 1'b0; dataIn = '0; clrCnt = 1'b0;
      srcS = 8'h01;

      applyStimulus(1'b1, 1'b1, 4'($urandom), 1'b1, "reset0");
      applyStimulus(1'b1, 1'b1, 4'($urandom), 1'b1, "reset1");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 4'($urandom), 1'b0, "idle");

      // Clean stream from seed 01: words 1, C, ... lock on the 6th word.
      for (int i = 0; i < 6; i++) sendWord(4'h0, 1'b0, "acquire");
      cleanRun(94, "clean");

      sendWord(4'h3, 1'b0, "singleErr");
      cleanRun(10, "afterSingle");

      for (int i = 0; i < 3; i++) sendWord(4'($urandom_range(1, 15)), 1'b0, "burst");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, "zeros");
      cleanRun(20, "relock");

      for (int i = 0; i < 20; i++) begin
         sendWord(4'($urandom_range(1, 15)), 1'b0, "saturate");
         cleanRun(2, "satClean");
      end

      sendWord(4'h3, 1'b1, "clrWithErr");
      cleanRun(3, "afterClr");
      sendWord(4'h0, 1'b1, "clrOnly");

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b0, 4'($urandom), 1'($urandom), "rndGap");
         sendWord(($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                  ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0, "random");
      end

      applyStimulus(1'b1, 1'b1, 4'($urandom), 1'b1, "midReset");
      cleanRun(10, "afterReset");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 4'($urandom), 1'b0, "tail");

      @(posedge Clk);
      #3;
      checkField("QueueDrained", "end", 32'(expQ.size()), 32'd0);
      checkField("PopCount", "end", 32'(popCount), 32'(pushCount));
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
